lagd_ic_reg_slave: RTL and testbench

Register-interface responder for one Ising core. It terminates the regbus port that Cheshire's external register demux routes to core `i`, at a byte window of `IC_NUM_REGS` bytes starting at `IC_REGS_BASE_ADDR + i*IC_NUM_REGS`. It holds the core's configuration and exposes status registers. A launch/abort control FSM hands jobs to the Ising logic over a valid/ready handshake.

---
 rtl/lagd_pkg.sv | 44 ++++
 rtl/lagd_ic_ctrl_fsm.sv | 85 ++++++++
 rtl/lagd_ic_reg_slave.sv | 156 +++++++++++++++
 tb/tb_lagd_ic_reg_slave.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lagd_pkg.sv
// Shared types and constants for the LAGD Ising-core register slave:
// register word offsets, CTRL/STATUS bit positions and control FSM states.
package lagd_pkg;

  localparam int unsigned CVA6_ADDR_WIDTH = 64;
  localparam int unsigned IC_NUM_REGS     = 64;

  typedef enum logic [2:0] {
    IcRegCtrl     = 3'd0,
    IcRegStatus   = 3'd1,
    IcRegNumIter  = 3'd2,
    IcRegJBase    = 3'd3,
    IcRegHBase    = 3'd4,
    IcRegSpinBase = 3'd5,
    IcRegCycles   = 3'd6,
    IcRegEnergy   = 3'd7
  } ic_reg_off_e;

  localparam int unsigned IcCtrlStart = 0;
  localparam int unsigned IcCtrlAbort = 1;
  localparam int unsigned IcCtrlIrqEn = 2;

  localparam int unsigned IcStatusBusy = 0;
  localparam int unsigned IcStatusDone = 1;
  localparam int unsigned IcStatusErr  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } ic_ctrl_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lagd_ic_ctrl_fsm.sv
// Launch/abort control FSM for one Ising core plus the optional CYCLES
// counter (present only when LAGD_IC_REG_PERF_EN is defined).
module lagd_ic_ctrl_fsm
  import lagd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_req_i,
  input  logic        abort_req_i,
  output logic        start_valid_o,
  input  logic        start_ready_i,
  output logic        abort_o,
  input  logic        done_i,
  output logic        busy_o,
  output logic        done_evt_o,
  output logic        abort_evt_o,
  output logic [31:0] cycles_o
);

  ic_ctrl_state_e state_q, state_d;
  logic           abort_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_evt_o;
    end
  end

  // A completing job beats a simultaneous abort: done is checked first in RUN.
  always_comb begin
    state_d       = state_q;
    done_evt_o    = 1'b0;
    abort_evt_o   = 1'b0;
    start_valid_o = (state_q == LAUNCH);
    unique case (state_q)
      IDLE: begin
        if (start_req_i) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (abort_req_i) begin
          abort_evt_o = 1'b1;
          state_d     = IDLE;
        end else if (start_ready_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (done_i) begin
          done_evt_o = 1'b1;
          state_d    = IDLE;
        end else if (abort_req_i) begin
          abort_evt_o = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign abort_o = abort_q;

`ifdef LAGD_IC_REG_PERF_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycles_q <= '0;
    end else if (state_q == IDLE && start_req_i) begin
      cycles_q <= '0;
    end else if (state_q != IDLE && cycles_q != '1) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: rtl/lagd_ic_reg_slave.sv
// Regbus responder for one Ising core: address decode, config/status
// registers and the control FSM. LAGD_IC_REG_PERF_EN enables the CYCLES counter.
module lagd_ic_reg_slave
  import lagd_pkg::*;
#(
  parameter int unsigned          AddrWidth = CVA6_ADDR_WIDTH,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter int unsigned          SpanB     = IC_NUM_REGS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 start_valid_o,
  input  logic                 start_ready_i,
  output logic                 abort_o,
  input  logic                 done_i,
  input  logic [31:0]          energy_i,
  output logic                 irq_o
);

  localparam int unsigned OffW = $clog2(SpanB) - 2;

  logic [AddrWidth-1:0] rel_addr;
  logic [OffW-1:0]      word_off;
  logic                 in_range, mapped, acc_err, bad_write;
  ic_reg_off_e          reg_off;
  logic [31:0]          rdata_c;

  logic        ready_q, error_q, wr_q;
  logic [31:0] rdata_q, wdata_q;
  logic [3:0]  wstrb_q;
  ic_reg_off_e wr_off_q;

  logic        irq_en_q, done_q, err_q;
  logic [31:0] num_iter_q, j_base_q, h_base_q, spin_base_q, energy_q;

  logic        busy, done_evt, abort_evt, start_req, abort_req;
  logic        wr_ctrl, wr_status;
  logic [31:0] cycles;

  assign rel_addr = reg_addr_i - BaseAddr;
  assign in_range = (rel_addr < AddrWidth'(SpanB));
  assign word_off = rel_addr[OffW+1:2];
  assign mapped   = (word_off < OffW'(8));
  assign reg_off  = ic_reg_off_e'(word_off[2:0]);

  always_comb begin
    rdata_c   = '0;
    bad_write = 1'b0;
    if (mapped) begin
      unique case (reg_off)
        IcRegCtrl: begin
          rdata_c[IcCtrlIrqEn] = irq_en_q;
          bad_write = reg_write_i && reg_wstrb_i[0] && reg_wdata_i[IcCtrlStart] && busy;
        end
        IcRegStatus: begin
          rdata_c[IcStatusBusy] = busy;
          rdata_c[IcStatusDone] = done_q;
          rdata_c[IcStatusErr]  = err_q;
        end
        IcRegNumIter:  begin rdata_c = num_iter_q;  bad_write = reg_write_i && busy; end
        IcRegJBase:    begin rdata_c = j_base_q;    bad_write = reg_write_i && busy; end
        IcRegHBase:    begin rdata_c = h_base_q;    bad_write = reg_write_i && busy; end
        IcRegSpinBase: begin rdata_c = spin_base_q; bad_write = reg_write_i && busy; end
        IcRegCycles:   begin rdata_c = cycles;      bad_write = reg_write_i; end
        IcRegEnergy:   begin rdata_c = energy_q;    bad_write = reg_write_i; end
        default:       rdata_c = '0;
      endcase
    end
    acc_err = !in_range || (reg_addr_i[1:0] != 2'b00) || bad_write;
  end

  // Request captured in cycle N, responded and committed in N+1; the
  // !ready_q guard stops the still-held valid from being taken twice.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      wr_off_q <= IcRegCtrl;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (reg_valid_i && !ready_q) begin
      ready_q  <= 1'b1;
      error_q  <= acc_err;
      rdata_q  <= acc_err ? '0 : rdata_c;
      wr_q     <= reg_write_i && !acc_err && mapped;
      wr_off_q <= reg_off;
      wdata_q  <= reg_wdata_i;
      wstrb_q  <= reg_wstrb_i;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end
  end

  assign wr_ctrl   = wr_q && (wr_off_q == IcRegCtrl)   && wstrb_q[0];
  assign wr_status = wr_q && (wr_off_q == IcRegStatus) && wstrb_q[0];
  assign start_req = wr_ctrl && wdata_q[IcCtrlStart];
  assign abort_req = wr_ctrl && wdata_q[IcCtrlAbort];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      num_iter_q  <= '0;
      j_base_q    <= '0;
      h_base_q    <= '0;
      spin_base_q <= '0;
      energy_q    <= '0;
    end else begin
      if (wr_ctrl) irq_en_q <= wdata_q[IcCtrlIrqEn];
      if (done_evt)                                   done_q <= 1'b1;
      else if (wr_status && wdata_q[IcStatusDone])    done_q <= 1'b0;
      if (abort_evt)                                  err_q  <= 1'b1;
      else if (wr_status && wdata_q[IcStatusErr])     err_q  <= 1'b0;
      if (done_evt) energy_q <= energy_i;
      if (wr_q && wr_off_q == IcRegNumIter)  num_iter_q  <= apply_wstrb(num_iter_q,  wdata_q, wstrb_q);
      if (wr_q && wr_off_q == IcRegJBase)    j_base_q    <= apply_wstrb(j_base_q,    wdata_q, wstrb_q);
      if (wr_q && wr_off_q == IcRegHBase)    h_base_q    <= apply_wstrb(h_base_q,    wdata_q, wstrb_q);
      if (wr_q && wr_off_q == IcRegSpinBase) spin_base_q <= apply_wstrb(spin_base_q, wdata_q, wstrb_q);
    end
  end

  lagd_ic_ctrl_fsm u_ctrl_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_req_i   (start_req),
    .abort_req_i   (abort_req),
    .start_valid_o (start_valid_o),
    .start_ready_i (start_ready_i),
    .abort_o       (abort_o),
    .done_i        (done_i),
    .busy_o        (busy),
    .done_evt_o    (done_evt),
    .abort_evt_o   (abort_evt),
    .cycles_o      (cycles)
  );

  assign reg_ready_o = ready_q;
  assign reg_rdata_o = rdata_q;
  assign reg_error_o = error_q;
  assign irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_lagd_ic_reg_slave.sv
// Directed self-checking bench for lagd_ic_reg_slave; expected CYCLES
// value follows LAGD_IC_REG_PERF_EN.
module tb_lagd_ic_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned SPAN = 64;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        reg_valid_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [31:0] reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [3:0]  reg_wstrb_i = '0;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        start_valid_o;
  logic        start_ready_i = 1'b0;
  logic        abort_o;
  logic        done_i = 1'b0;
  logic [31:0] energy_i = '0;
  logic        irq_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lagd_ic_reg_slave #(
    .AddrWidth (32),
    .BaseAddr  (BASE),
    .SpanB     (SPAN)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .reg_valid_i   (reg_valid_i),
    .reg_write_i   (reg_write_i),
    .reg_addr_i    (reg_addr_i),
    .reg_wdata_i   (reg_wdata_i),
    .reg_wstrb_i   (reg_wstrb_i),
    .reg_ready_o   (reg_ready_o),
    .reg_rdata_o   (reg_rdata_o),
    .reg_error_o   (reg_error_o),
    .start_valid_o (start_valid_o),
    .start_ready_i (start_ready_i),
    .abort_o       (abort_o),
    .done_i        (done_i),
    .energy_i      (energy_i),
    .irq_o         (irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic acc(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    @(negedge clk);
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = wstrb;
    @(posedge clk);
    #1;
    chk({tag, "_ready"}, {31'd0, reg_ready_o}, 32'd1);
    chk({tag, "_err"},   {31'd0, reg_error_o}, {31'd0, exp_err});
    if (chk_rd) chk({tag, "_rdata"}, reg_rdata_o, exp_rd);
    @(negedge clk);
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask

  function automatic logic [31:0] wa(input int unsigned off);
    return BASE + 32'(off * 4);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_ready", {31'd0, reg_ready_o}, 32'd0);
    chk("rst_start_valid", {31'd0, start_valid_o}, 32'd0);
    chk("rst_abort", {31'd0, abort_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    acc("rd_status0", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h0);
    acc("rd_ctrl0",   1'b0, wa(0), '0, 4'h0, 1'b0, 1'b1, 32'h0);

    // Strobed config write and readback
    acc("wr_numiter", 1'b1, wa(2), 32'hDEAD_1234, 4'b0011, 1'b0, 1'b0, 32'h0);
    acc("rd_numiter", 1'b0, wa(2), '0, 4'h0, 1'b0, 1'b1, 32'h0000_1234);
    acc("wr_jbase",   1'b1, wa(3), 32'hA5A5_0001, 4'hF, 1'b0, 1'b0, 32'h0);

    // Job 1: START + IRQ_EN, 3 cycles of back-pressure, done 10 cycles after accept
    acc("wr_start1", 1'b1, wa(0), 32'h5, 4'h1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("launch_valid", {31'd0, start_valid_o}, 32'd1);
    repeat (4) @(negedge clk);
    start_ready_i = 1'b1;
    @(negedge clk);
    start_ready_i = 1'b0;
    chk("run_valid_low", {31'd0, start_valid_o}, 32'd0);
    acc("rd_status_busy", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h1);
    repeat (7) @(negedge clk);
    done_i = 1'b1;
    energy_i = 32'hFFFF_FF80;
    @(negedge clk);
    done_i = 1'b0;
    energy_i = 32'h0;
    chk("irq_after_done", {31'd0, irq_o}, 32'd1);
    acc("rd_energy", 1'b0, wa(7), '0, 4'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
    acc("rd_status_done", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h2);
`ifdef LAGD_IC_REG_PERF_EN
    acc("rd_cycles", 1'b0, wa(6), '0, 4'h0, 1'b0, 1'b1, 32'd14);
`else
    acc("rd_cycles", 1'b0, wa(6), '0, 4'h0, 1'b0, 1'b1, 32'd0);
`endif
    acc("rd_ctrl_irqen", 1'b0, wa(0), '0, 4'h0, 1'b0, 1'b1, 32'h4);
    acc("w1c_done", 1'b1, wa(1), 32'h2, 4'h1, 1'b0, 1'b0, 32'h0);
    acc("rd_status_clr", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h0);
    chk("irq_cleared", {31'd0, irq_o}, 32'd0);

    // Job 2: busy-time write errors, then abort in RUN
    start_ready_i = 1'b1;
    acc("wr_start2", 1'b1, wa(0), 32'h5, 4'h1, 1'b0, 1'b0, 32'h0);
    acc("wr_jbase_busy", 1'b1, wa(3), 32'h1111_2222, 4'hF, 1'b1, 1'b0, 32'h0);
    start_ready_i = 1'b0;
    acc("wr_start_busy", 1'b1, wa(0), 32'h1, 4'h1, 1'b1, 1'b0, 32'h0);
    acc("rd_jbase_kept", 1'b0, wa(3), '0, 4'h0, 1'b0, 1'b1, 32'hA5A5_0001);
    acc("wr_abort", 1'b1, wa(0), 32'h6, 4'h1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("abort_pulse", {31'd0, abort_o}, 32'd1);
    @(posedge clk); #1;
    chk("abort_one_cycle", {31'd0, abort_o}, 32'd0);
    acc("rd_status_err", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h4);
    acc("w1c_err", 1'b1, wa(1), 32'h4, 4'h1, 1'b0, 1'b0, 32'h0);
    acc("rd_status_err_clr", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h0);
    acc("wr_abort_idle", 1'b1, wa(0), 32'h6, 4'h1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("abort_idle_none", {31'd0, abort_o}, 32'd0);
    acc("rd_status_idle", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h0);

    // Decode boundaries
    acc("rd_past_span", 1'b0, BASE + SPAN, '0, 4'h0, 1'b1, 1'b1, 32'h0);
    acc("rd_misalign",  1'b0, BASE + 32'd2, '0, 4'h0, 1'b1, 1'b1, 32'h0);
    acc("rd_below_base", 1'b0, BASE - 32'd4, '0, 4'h0, 1'b1, 1'b1, 32'h0);
    acc("rd_off9", 1'b0, wa(9), '0, 4'h0, 1'b0, 1'b1, 32'h0);
    acc("wr_off9", 1'b1, wa(9), 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0);
    acc("wr_energy", 1'b1, wa(7), 32'h1, 4'hF, 1'b1, 1'b0, 32'h0);
    acc("wr_cycles", 1'b1, wa(6), 32'h1, 4'hF, 1'b1, 1'b0, 32'h0);
    acc("rd_energy_kept", 1'b0, wa(7), '0, 4'h0, 1'b0, 1'b1, 32'hFFFF_FF80);

    // Reset mid-job: outputs drop without waiting for a clock edge
    acc("wr_start3", 1'b1, wa(0), 32'h1, 4'h1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("launch3_valid", {31'd0, start_valid_o}, 32'd1);
    @(negedge clk); #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, start_valid_o}, 32'd0);
    chk("async_rst_abort", {31'd0, abort_o}, 32'd0);
    chk("async_rst_ready", {31'd0, reg_ready_o}, 32'd0);
    chk("async_rst_irq",   {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    acc("rd_status_post_rst", 1'b0, wa(1), '0, 4'h0, 1'b0, 1'b1, 32'h0);
    acc("rd_jbase_post_rst",  1'b0, wa(3), '0, 4'h0, 1'b0, 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
